// File: rtl/i2c_reg_master_if.sv
// i2c_reg_master_if: request port and byte-primitive port of the register sequencer.
`default_nettype none

interface i2c_reg_master_if;
  logic        req_i;
  logic        we_i;
  logic [6:0]  dev_addr_i;
  logic [7:0]  reg_addr_i;
  logic [1:0]  len_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        error_o;
  logic [1:0]  i2c_instruction_o;
  logic        i2c_enable_o;
  logic [7:0]  i2c_byte_o;
  logic [7:0]  i2c_byte_i;
  logic        i2c_complete_i;

  modport master (
    input  req_i, we_i, dev_addr_i, reg_addr_i, len_i, wdata_i,
    output ready_o, done_o, rdata_o, error_o,
    output i2c_instruction_o, i2c_enable_o, i2c_byte_o,
    input  i2c_byte_i, i2c_complete_i
  );

  modport slave (
    output req_i, we_i, dev_addr_i, reg_addr_i, len_i, wdata_i,
    input  ready_o, done_o, rdata_o, error_o,
    input  i2c_instruction_o, i2c_enable_o, i2c_byte_o,
    output i2c_byte_i, i2c_complete_i
  );
endinterface

`default_nettype wire

// File: rtl/i2c_reg_master.sv
// ============================================================================
// i2c_reg_master: sequences one 1-4 byte register read/write over the byte-level
// i2c primitive. Optional watchdog: define I2C_REG_MASTER_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_reg_master #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  i2c_reg_master_if.master  bus
);

  localparam logic [1:0] c_INS_START = 2'b00;
  localparam logic [1:0] c_INS_STOP  = 2'b01;
  localparam logic [1:0] c_INS_READ  = 2'b10;
  localparam logic [1:0] c_INS_WRITE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_CLR  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RELEASE   = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [6:0]  r_dev;
  logic [7:0]  r_reg;
  logic [1:0]  r_len;
  logic [31:0] r_wdata;
  logic [3:0]  r_op;
  logic [1:0]  r_k;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_timeout;
  logic [3:0]  w_last_op;
  logic [1:0]  w_didx;
  logic [1:0]  w_instr;
  logic [7:0]  w_byte;
  logic        w_ready;
  logic        w_done;
  logic        w_enable;

  assign w_accept  = (r_state == S_IDLE) && bus.req_i;
  assign w_last_op = {2'b00, r_len} + (r_we ? 4'd4 : 4'd6);
  // Write data ops start at index 3, so byte index = op - 3 = op + 1 (mod 4).
  assign w_didx    = r_op[1:0] + 2'd1;

  always_comb begin
    w_instr = c_INS_START;
    w_byte  = 8'h00;
    if (r_op == 4'd0) begin
      w_instr = c_INS_START;
    end else if (r_op == 4'd1) begin
      w_instr = c_INS_WRITE;
      w_byte  = {r_dev, 1'b0};
    end else if (r_op == 4'd2) begin
      w_instr = c_INS_WRITE;
      w_byte  = r_reg;
    end else if (r_op == w_last_op) begin
      w_instr = c_INS_STOP;
    end else if (r_we) begin
      w_instr = c_INS_WRITE;
      w_byte  = r_wdata[{w_didx, 3'b000} +: 8];
    end else if (r_op == 4'd3) begin
      w_instr = c_INS_START;
    end else if (r_op == 4'd4) begin
      w_instr = c_INS_WRITE;
      w_byte  = {r_dev, 1'b1};
    end else begin
      w_instr = c_INS_READ;
    end
  end

`ifdef I2C_REG_MASTER_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [c_TO_W-1:0] r_to;
  logic              r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to <= '0;
    end else if (r_state == S_ISSUE) begin
      r_to <= '0;
    end else if (r_state == S_WAIT_CLR || r_state == S_WAIT_DONE) begin
      r_to <= r_to + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_WAIT_CLR || r_state == S_WAIT_DONE) &&
                     (r_to == c_TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign bus.error_o = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
  assign bus.error_o      = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_ready  = 1'b0;
    w_done   = 1'b0;
    w_enable = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.req_i) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_enable = 1'b1;
        w_next   = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        w_enable = 1'b1;
        if (w_timeout)               w_next = S_FINISH;
        else if (!bus.i2c_complete_i) w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        w_enable = 1'b1;
        if (bus.i2c_complete_i) w_next = S_RELEASE;
        else if (w_timeout)     w_next = S_FINISH;
      end
      S_RELEASE: begin
        w_next = (r_op == w_last_op) ? S_FINISH : S_ISSUE;
      end
      S_FINISH: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_dev   <= 7'd0;
      r_reg   <= 8'd0;
      r_len   <= 2'd0;
      r_wdata <= 32'd0;
      r_op    <= 4'd0;
      r_k     <= 2'd0;
      r_rdata <= 32'd0;
    end else if (w_accept) begin
      r_we    <= bus.we_i;
      r_dev   <= bus.dev_addr_i;
      r_reg   <= bus.reg_addr_i;
      r_len   <= bus.len_i;
      r_wdata <= bus.wdata_i;
      r_op    <= 4'd0;
      r_k     <= 2'd0;
      r_rdata <= 32'd0;
    end else begin
      if (r_state == S_WAIT_DONE && bus.i2c_complete_i && w_instr == c_INS_READ) begin
        r_rdata[{r_k, 3'b000} +: 8] <= bus.i2c_byte_i;
        r_k                         <= r_k + 2'd1;
      end
      if (r_state == S_RELEASE && r_op != w_last_op) begin
        r_op <= r_op + 4'd1;
      end
    end
  end

  assign bus.ready_o           = w_ready;
  assign bus.done_o            = w_done;
  assign bus.rdata_o           = r_rdata;
  assign bus.i2c_instruction_o = w_instr;
  assign bus.i2c_byte_o        = w_byte;
  assign bus.i2c_enable_o      = w_enable;

endmodule

`default_nettype wire

// File: tb/tb_i2c_reg_master.sv
// tb_i2c_reg_master: directed bench with a behavioural byte-primitive model and op log.
`default_nettype none

module tb_i2c_reg_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2c_reg_master_if bus();

  i2c_reg_master #(.TIMEOUT_CYCLES(64)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Primitive model: accepts an op on enable in idle, clears complete next cycle,
  // raises complete 4 cycles later, returns to idle when enable drops.
  logic [1:0] m_st;
  int         m_dly;
  logic       hang = 1'b0;
  logic [7:0] rd_q [0:3];
  logic [1:0] rd_ptr;
  logic [1:0] lg_i [0:127];
  logic [7:0] lg_b [0:127];
  int         log_n = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st               <= 2'd0;
      m_dly              <= 0;
      rd_ptr             <= 2'd0;
      bus.i2c_complete_i <= 1'b0;
      bus.i2c_byte_i     <= 8'h00;
    end else begin
      case (m_st)
        2'd0: if (bus.i2c_enable_o) begin
          m_st               <= 2'd1;
          m_dly              <= 3;
          bus.i2c_complete_i <= 1'b0;
          lg_i[log_n[6:0]]   <= bus.i2c_instruction_o;
          lg_b[log_n[6:0]]   <= bus.i2c_byte_o;
          log_n              <= log_n + 1;
          if (bus.i2c_instruction_o == 2'b00) rd_ptr <= 2'd0;
        end
        2'd1: begin
          if (!bus.i2c_enable_o) begin
            m_st <= 2'd0;
          end else if (!hang) begin
            if (m_dly == 0) begin
              m_st               <= 2'd2;
              bus.i2c_complete_i <= 1'b1;
              if (bus.i2c_instruction_o == 2'b10) begin
                bus.i2c_byte_i <= rd_q[rd_ptr];
                rd_ptr         <= rd_ptr + 2'd1;
              end
            end else begin
              m_dly <= m_dly - 1;
            end
          end
        end
        default: if (!bus.i2c_enable_o) m_st <= 2'd0;
      endcase
    end
  end

  int          done_cnt = 0;
  int          low_cnt  = 0;
  int          acc_cnt  = 0;
  logic [31:0] rd_at_done;
  logic        err_at_done;

  always @(negedge clk) begin
    if (bus.done_o) begin
      done_cnt    = done_cnt + 1;
      rd_at_done  = bus.rdata_o;
      err_at_done = bus.error_o;
    end
    if (!bus.i2c_enable_o && !bus.ready_o && !bus.done_o) low_cnt = low_cnt + 1;
  end

  always @(posedge clk) begin
    if (rst_n && bus.req_i && bus.ready_o) acc_cnt = acc_cnt + 1;
  end

  task automatic start_req(input logic we, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [1:0] len, input logic [31:0] wd);
    @(negedge clk);
    bus.we_i       = we;
    bus.dev_addr_i = dev;
    bus.reg_addr_i = ra;
    bus.len_i      = len;
    bus.wdata_i    = wd;
    bus.req_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_i = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (bus.done_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done_o); end
    checks++; if (bus.error_o !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", bus.error_o); end
    checks++; if (bus.i2c_enable_o !== 1'b0) begin errors++; $display("FAIL reset_enable got %b want 0", bus.i2c_enable_o); end
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus.rdata_o); end
    checks++; if (bus.i2c_byte_o !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", bus.i2c_byte_o); end
    checks++; if (bus.i2c_instruction_o !== 2'b00) begin errors++; $display("FAIL reset_instr got %b want 00", bus.i2c_instruction_o); end
  endtask

  task automatic test_write_single;
    logic [9:0] exp [0:4];
    int b, d0;
    bit ok;
    exp[0] = {2'b00, 8'h00}; exp[1] = {2'b11, 8'h78}; exp[2] = {2'b11, 8'h00};
    exp[3] = {2'b11, 8'hAF}; exp[4] = {2'b01, 8'h00};
    b = log_n; d0 = done_cnt;
    start_req(1'b1, 7'h3C, 8'h00, 2'd0, 32'h0000_00AF);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr1_done got timeout want done"); end
    repeat (3) @(negedge clk);
    checks++; if (log_n - b !== 5) begin errors++; $display("FAIL wr1_opcount got %0d want 5", log_n - b); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({lg_i[b+i], lg_b[b+i]} !== exp[i]) begin
        errors++; $display("FAIL wr1_op%0d got %h want %h", i, {lg_i[b+i], lg_b[b+i]}, exp[i]);
      end
    end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL wr1_donecount got %0d want 1", done_cnt - d0); end
    checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL wr1_error got %b want 0", err_at_done); end
  endtask

  task automatic test_read_two;
    logic [9:0] exp [0:7];
    int b;
    bit ok;
    exp[0] = {2'b00, 8'h00}; exp[1] = {2'b11, 8'hA0}; exp[2] = {2'b11, 8'h10};
    exp[3] = {2'b00, 8'h00}; exp[4] = {2'b11, 8'hA1}; exp[5] = {2'b10, 8'h00};
    exp[6] = {2'b10, 8'h00}; exp[7] = {2'b01, 8'h00};
    rd_q[0] = 8'h12; rd_q[1] = 8'h34; rd_q[2] = 8'hEE; rd_q[3] = 8'hEE;
    b = log_n;
    start_req(1'b0, 7'h50, 8'h10, 2'd1, 32'hFFFF_FFFF);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd2_done got timeout want done"); end
    repeat (3) @(negedge clk);
    checks++; if (log_n - b !== 8) begin errors++; $display("FAIL rd2_opcount got %0d want 8", log_n - b); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({lg_i[b+i], lg_b[b+i]} !== exp[i]) begin
        errors++; $display("FAIL rd2_op%0d got %h want %h", i, {lg_i[b+i], lg_b[b+i]}, exp[i]);
      end
    end
    checks++; if (rd_at_done !== 32'h0000_3412) begin errors++; $display("FAIL rd2_rdata_done got %h want 00003412", rd_at_done); end
    checks++; if (bus.rdata_o !== 32'h0000_3412) begin errors++; $display("FAIL rd2_rdata_hold got %h want 00003412", bus.rdata_o); end
  endtask

  task automatic test_write_burst;
    logic [9:0] exp [0:7];
    int b, l0;
    bit ok;
    exp[0] = {2'b00, 8'h00}; exp[1] = {2'b11, 8'h78}; exp[2] = {2'b11, 8'h40};
    exp[3] = {2'b11, 8'h11}; exp[4] = {2'b11, 8'h22}; exp[5] = {2'b11, 8'h33};
    exp[6] = {2'b11, 8'h44}; exp[7] = {2'b01, 8'h00};
    b = log_n; l0 = low_cnt;
    start_req(1'b1, 7'h3C, 8'h40, 2'd3, 32'h4433_2211);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr4_done got timeout want done"); end
    repeat (3) @(negedge clk);
    checks++; if (log_n - b !== 8) begin errors++; $display("FAIL wr4_opcount got %0d want 8", log_n - b); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({lg_i[b+i], lg_b[b+i]} !== exp[i]) begin
        errors++; $display("FAIL wr4_op%0d got %h want %h", i, {lg_i[b+i], lg_b[b+i]}, exp[i]);
      end
    end
    // One low-enable cycle per op: seven gaps plus the final release.
    checks++; if (low_cnt - l0 !== 8) begin errors++; $display("FAIL wr4_enable_low got %0d want 8", low_cnt - l0); end
  endtask

  task automatic test_back_to_back;
    int b, a0;
    bit ok;
    b = log_n; a0 = acc_cnt;
    @(negedge clk);
    bus.we_i = 1'b1; bus.dev_addr_i = 7'h11; bus.reg_addr_i = 8'h22;
    bus.len_i = 2'd0; bus.wdata_i = 32'h0000_0033; bus.req_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.we_i = 1'b0; bus.dev_addr_i = 7'h22; bus.reg_addr_i = 8'h05;
    bus.len_i = 2'd0; bus.wdata_i = 32'h0000_00CC;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done1 got timeout want done"); end
    checks++; if (acc_cnt - a0 !== 1) begin errors++; $display("FAIL b2b_accepts_busy got %0d want 1", acc_cnt - a0); end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.req_i = 1'b0;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done2 got timeout want done"); end
    repeat (4) @(negedge clk);
    checks++; if (acc_cnt - a0 !== 2) begin errors++; $display("FAIL b2b_accepts got %0d want 2", acc_cnt - a0); end
    checks++; if (log_n - b !== 12) begin errors++; $display("FAIL b2b_opcount got %0d want 12", log_n - b); end
    checks++; if ({lg_i[b+1], lg_b[b+1]} !== {2'b11, 8'h22}) begin errors++; $display("FAIL b2b_a_dev got %h want 322", {lg_i[b+1], lg_b[b+1]}); end
    checks++; if ({lg_i[b+3], lg_b[b+3]} !== {2'b11, 8'h33}) begin errors++; $display("FAIL b2b_a_data got %h want 333", {lg_i[b+3], lg_b[b+3]}); end
    checks++; if ({lg_i[b+6], lg_b[b+6]} !== {2'b11, 8'h44}) begin errors++; $display("FAIL b2b_b_dev got %h want 344", {lg_i[b+6], lg_b[b+6]}); end
    checks++; if ({lg_i[b+7], lg_b[b+7]} !== {2'b11, 8'h05}) begin errors++; $display("FAIL b2b_b_reg got %h want 305", {lg_i[b+7], lg_b[b+7]}); end
    checks++; if ({lg_i[b+9], lg_b[b+9]} !== {2'b11, 8'h45}) begin errors++; $display("FAIL b2b_b_devrd got %h want 345", {lg_i[b+9], lg_b[b+9]}); end
  endtask

  task automatic test_reset_mid;
    int b, n;
    bit ok;
    b = log_n;
    start_req(1'b1, 7'h3C, 8'h01, 2'd0, 32'h0000_005A);
    for (n = 0; n < 200; n++) begin
      if (log_n - b >= 3) break;
      @(negedge clk);
    end
    checks++; if (log_n - b < 3) begin errors++; $display("FAIL rst_reach_op3 got %0d ops want 3", log_n - b); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", bus.ready_o); end
    checks++; if (bus.i2c_enable_o !== 1'b0) begin errors++; $display("FAIL rst_mid_enable got %b want 0", bus.i2c_enable_o); end
    checks++; if (bus.i2c_instruction_o !== 2'b00) begin errors++; $display("FAIL rst_mid_instr got %b want 00", bus.i2c_instruction_o); end
    checks++; if (bus.i2c_byte_o !== 8'h00) begin errors++; $display("FAIL rst_mid_byte got %h want 00", bus.i2c_byte_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", bus.done_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (log_n - b !== 3) begin errors++; $display("FAIL rst_no_stop got %0d ops want 3", log_n - b); end
    b = log_n;
    start_req(1'b1, 7'h3C, 8'h02, 2'd0, 32'h0000_00C3);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_after_done got timeout want done"); end
    repeat (3) @(negedge clk);
    checks++; if (log_n - b !== 5) begin errors++; $display("FAIL rst_after_opcount got %0d want 5", log_n - b); end
    checks++; if ({lg_i[b+3], lg_b[b+3]} !== {2'b11, 8'hC3}) begin errors++; $display("FAIL rst_after_data got %h want 3c3", {lg_i[b+3], lg_b[b+3]}); end
  endtask

`ifdef I2C_REG_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    bit ok;
    hang = 1'b1;
    start_req(1'b1, 7'h3C, 8'h00, 2'd0, 32'h0000_0001);
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.done_o) break;
    end
    checks++; if (n !== 64) begin errors++; $display("FAIL to_latency got %0d want 64", n); end
    checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL to_error_done got %b want 1", err_at_done); end
    hang = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.error_o !== 1'b1) begin errors++; $display("FAIL to_error_sticky got %b want 1", bus.error_o); end
    checks++; if (bus.i2c_enable_o !== 1'b0) begin errors++; $display("FAIL to_enable got %b want 0", bus.i2c_enable_o); end
    start_req(1'b1, 7'h3C, 8'h00, 2'd0, 32'h0000_0002);
    checks++; if (bus.error_o !== 1'b0) begin errors++; $display("FAIL to_error_clear got %b want 0", bus.error_o); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_next_done got timeout want done"); end
    checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL to_next_error got %b want 0", err_at_done); end
  endtask
`endif

  initial begin
    bus.req_i      = 1'b0;
    bus.we_i       = 1'b0;
    bus.dev_addr_i = 7'h00;
    bus.reg_addr_i = 8'h00;
    bus.len_i      = 2'd0;
    bus.wdata_i    = 32'h0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_write_single;
    test_read_two;
    test_write_burst;
    test_back_to_back;
    test_reset_mid;
`ifdef I2C_REG_MASTER_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_reg_master.md
# i2c_reg_master

Register-level transaction sequencer for the byte-level `i2c` primitive in the TangNano20K I2C path. It accepts one register read or write request of 1–4 bytes. It then drives the primitive's instruction/enable handshake through START, address, register, optional repeated START, data and STOP. Read bytes are packed into a word for the requester, and an optional watchdog aborts a hung primitive.

## Interface
- `TIMEOUT_CYCLES`, default 4096: per-primitive-operation watchdog limit in clk_i cycles. Used only with `I2C_REG_MASTER_TIMEOUT_EN`.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_i` in 1: request; accepted when `req_i && ready_o`.
- `we_i` in 1: 1 = register write, 0 = register read.
- `dev_addr_i` in 7: 7-bit device address.
- `reg_addr_i` in 8: register address.
- `len_i` in 2: byte count minus 1 (0..3 → 1..4 bytes).
- `wdata_i` in 32: write data; byte k = `wdata_i[8k+7:8k]`, byte 0 sent first.
- `ready_o` out 1: high in IDLE only.
- `done_o` out 1: one-cycle pulse at transaction end, including aborts.
- `rdata_o` out 32: read data, byte k in `[8k+7:8k]`, unread bytes 0; held until the next accept.
- `error_o` out 1: watchdog abort flag, sticky until the next accept.
- `i2c_instruction_o` out 2: 00 start, 01 stop, 10 read+ACK, 11 write+ACK.
- `i2c_enable_o` out 1: primitive enable.
- `i2c_byte_o` out 8: byte to send.
- `i2c_byte_i` in 8: byte received from the primitive.
- `i2c_complete_i` in 1: primitive complete.

## Operation
- Reset values:
  - `ready_o` = 1.
  - `done_o`, `error_o`, `i2c_enable_o` = 0.
  - `rdata_o`, `i2c_byte_o` = 0.
  - `i2c_instruction_o` = 00.
  - Sequencer in IDLE, phase = START.
- Accept: latch `we_i`, `dev_addr_i`, `reg_addr_i`, `len_i`, `wdata_i`. Clear `rdata_o`, `error_o` and the byte counter.
- Write op list:
  - START
  - WRITE `{dev,0}`
  - WRITE `reg`
  - WRITE data byte 0..len
  - STOP
  - Total ops: len+5.
- Read op list:
  - START
  - WRITE `{dev,0}`
  - WRITE `reg`
  - START (repeated)
  - WRITE `{dev,1}`
  - READ ×(len+1)
  - STOP
  - Total ops: len+7.
- Every READ ACKs, including the last; the primitive has no NACK option. ACK bits are not checked.
- Handshake FSM, one pass per op: ISSUE → WAIT_CLR → WAIT_DONE → RELEASE → (next op: ISSUE | list exhausted: FINISH) → IDLE.
  - ISSUE: drive instruction/byte; `i2c_enable_o` = 1 from ISSUE through WAIT_DONE.
  - WAIT_CLR: wait for `i2c_complete_i` == 0. This guards against the stale complete from the previous op.
  - WAIT_DONE: wait for `i2c_complete_i` == 1. On a READ, write `i2c_byte_i` into `rdata_o` byte slot k, then k++.
  - RELEASE: `i2c_enable_o` = 0 for exactly 1 cycle, which returns the primitive to idle.
  - FINISH: `done_o` = 1 for 1 cycle, `ready_o` rises next cycle.
- Instruction and byte outputs are stable for the whole ISSUE..WAIT_DONE window.
- `req_i` outside IDLE is ignored and not queued.
- Reset mid-transaction: immediate return to reset values. No STOP is issued and no `done_o` pulse is produced.

## Timing
- Accept to first ISSUE: 1 cycle.
- Per-op overhead beyond the primitive's own duration:
  - WAIT_CLR takes 2 cycles, because complete clears one cycle after enable is seen in primitive IDLE.
  - RELEASE adds 1 cycle.
- Last WAIT_DONE complete → RELEASE → FINISH: `done_o` asserts 2 cycles after complete is seen.
- `rdata_o` is valid in the `done_o` cycle.
- `len_i` is fully decoded; no illegal values exist.

## Configuration
- `I2C_REG_MASTER_TIMEOUT_EN` defined:
  - A counter clears in ISSUE and increments in WAIT_CLR and WAIT_DONE.
  - Reaching `TIMEOUT_CYCLES-1` triggers an abort: `i2c_enable_o` = 0, `error_o` = 1, then FINISH (`done_o` pulse) and IDLE.
  - No STOP is attempted after an abort.
- Undefined: no counter, `error_o` tied 0, and the FSM waits indefinitely.

## Test plan
- Write, dev 0x3C, reg 0x00, len 0, wdata 0xAF:
  - Ops seen: 00, 11/0x78, 11/0x00, 11/0xAF, 01.
  - One `done_o`, `error_o` = 0.
- Read, dev 0x50, reg 0x10, len 1; model returns 0x12 then 0x34:
  - Ops seen: 00, 11/0xA0, 11/0x10, 00, 11/0xA1, 10, 10, 01.
  - `rdata_o` = 0x00003412.
- Write, len 3, wdata 0x44332211:
  - Data bytes sent in order 0x11, 0x22, 0x33, 0x44.
  - `i2c_enable_o` is low exactly 1 cycle between each pair of ops.
- `req_i` held high during a transaction with different inputs:
  - No second transaction starts until `ready_o`.
  - The next accept uses the inputs present at that cycle.
- With `I2C_REG_MASTER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 64, model never raises complete:
  - `done_o` and `error_o` = 1 after 64 cycles in wait.
  - `error_o` clears on the next accept.
- `rst_ni` pulsed low during the 3rd op:
  - All outputs return to reset values asynchronously.
  - A new request afterwards completes normally.
